multicycle_controller: RTL and testbench

Control FSM for the multi-cycle RV32I core. Sequences fetch/decode/execute/memory/writeback over a single shared ALU, memory and register file. Drives the 3-bit immediate-format select into the immediate extender, plus all datapath mux selects and write enables. Sits beside the datapath and sees only opcode, funct fields and ALU flags.

---
 rtl/rv_ctrl_pkg.sv | 70 +++++++
 rtl/alu_decoder.sv | 38 +++
 rtl/multicycle_controller.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_pkg
// Purpose  : Shared encodings for the multi-cycle RV32I control path:
//            opcodes, FSM states, and datapath select codes.
// Revision : 1.0  initial release
// ============================================================================
package rv_ctrl_pkg;

  // RV32I opcodes recognised by the controller
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR_PC  = 4'd12,
    S_LUI      = 4'd13
  } state_e;

  // Immediate-format select, shared with the immediate extender
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMMEXT = 2'b11;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage : rv_ctrl_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Combinational funct3/funct7 decode to ALU operation for
//            R-type and I-type ALU instructions; flags unsupported funct3.
// Revision : 1.0  initial release
// ============================================================================
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [2:0] alu_control_o,
  output logic       bad_funct_o
);

  logic is_rtype;

  // funct7_5 only selects sub for register-register ops; addi ignores it
  assign is_rtype = (op_i == OP_RTYPE);

  // Map funct3 to ALU operation; unsupported codes fall back to add
  always_comb begin
    alu_control_o = ALU_ADD;
    bad_funct_o   = 1'b0;
    case (funct3_i)
      3'b000:  alu_control_o = (is_rtype && funct7_5_i) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_control_o = ALU_AND;
      3'b110:  alu_control_o = ALU_OR;
      3'b100:  alu_control_o = ALU_XOR;
      3'b010:  alu_control_o = ALU_SLT;
      default: bad_funct_o   = 1'b1;
    endcase
  end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Control FSM for the multi-cycle RV32I core. Sequences fetch,
//            decode, execute, memory and writeback over a shared datapath.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_controller
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       neg,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [2:0] dec_alu_control;
  logic       dec_bad_funct;
  logic       branch_taken;
  logic       branch_bad;

  // Ungated enables; reset forces them low at the output stage
  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       illegal_raw;

  alu_decoder u_alu_decoder (
    .op_i          (op),
    .funct3_i      (funct3),
    .funct7_5_i    (funct7_5),
    .alu_control_o (dec_alu_control),
    .bad_funct_o   (dec_bad_funct)
  );

  // Branch condition from funct3 and the ALU flags of rs1 - rs2
  always_comb begin
    branch_taken = 1'b0;
    branch_bad   = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = neg;
      3'b101:  branch_taken = ~neg;
      default: branch_bad   = 1'b1;
    endcase
  end

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state and Moore/Mealy datapath controls
  always_comb begin
    state_d       = state_q;
    pc_write_raw  = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    result_src    = RES_ALUOUT;
    alu_control   = ALU_ADD;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    imm_src       = IMM_I;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALURES;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        // Precompute OldPC + imm so branch/jal targets sit in ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default: begin
            illegal_raw = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_LOAD) ? IMM_I : IMM_S;
        state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        state_d    = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = RES_MEMDATA;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        result_src    = RES_ALUOUT;
        mem_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = dec_alu_control;
        illegal_raw = dec_bad_funct;
        state_d     = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_I;
        alu_control = dec_alu_control;
        illegal_raw = dec_bad_funct;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        result_src    = RES_ALUOUT;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        // ALUOut still holds the target computed in DECODE
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_RS2;
        alu_control  = ALU_SUB;
        result_src   = RES_ALUOUT;
        pc_write_raw = branch_taken;
        illegal_raw  = branch_bad;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        // Jump to ALUOut while computing the link value OldPC + 4
        pc_write_raw = 1'b1;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        state_d      = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        state_d   = S_JALR_PC;
      end
      S_JALR_PC: begin
        pc_write_raw = 1'b1;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        state_d      = S_ALUWB;
      end
      S_LUI: begin
        imm_src       = IMM_U;
        result_src    = RES_IMMEXT;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural side effects are suppressed for as long as reset is held
  assign pc_write  = rst & pc_write_raw;
  assign mem_write = rst & mem_write_raw;
  assign ir_write  = rst & ir_write_raw;
  assign reg_write = rst & reg_write_raw;
  assign illegal   = rst & illegal_raw;

endmodule : multicycle_controller
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Self-checking bench: directed and random instruction streams
//            compared cycle by cycle against a per-instruction output model.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .zero        (zero),
    .neg         (neg),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_control (alu_control),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .reg_write   (reg_write),
    .illegal     (illegal)
  );

  // 10 ns core clock
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Output vector: {pc_write, adr_src, mem_write, ir_write, result_src,
  //                 alu_control, alu_src_a, alu_src_b, imm_src, reg_write, illegal}
  function automatic logic [17:0] mk(input bit pw, input bit adr, input bit mw, input bit irw,
                                     input logic [1:0] rs, input logic [2:0] alu,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] imm, input bit rw, input bit ill);
    return {pw, adr, mw, irw, rs, alu, sa, sb, imm, rw, ill};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
            alu_src_a, alu_src_b, imm_src, reg_write, illegal};
  endfunction

  function automatic logic [4:0] dut_enables();
    return {pc_write, mem_write, ir_write, reg_write, illegal};
  endfunction

  // Reference ALU op: add 0, sub 1, and 2, or 3, xor 4, slt 5
  function automatic void ref_alu(input bit is_r, input logic [2:0] f3, input bit f7,
                                  output logic [2:0] alu, output bit bad);
    bad = 1'b0;
    alu = 3'd0;
    if (f3 == 3'd0)      alu = (is_r && f7) ? 3'd1 : 3'd0;
    else if (f3 == 3'd7) alu = 3'd2;
    else if (f3 == 3'd6) alu = 3'd3;
    else if (f3 == 3'd4) alu = 3'd4;
    else if (f3 == 3'd2) alu = 3'd5;
    else                 bad = 1'b1;
  endfunction

  function automatic bit known_op(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
  endfunction

  // Cycles an instruction occupies, from the latency table
  function automatic int instr_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011: return 4;
      7'b0110011: return 4;
      7'b0010011: return 4;
      7'b1100011: return 3;
      7'b1101111: return 4;
      7'b1100111: return 5;
      7'b0110111: return 3;
      default:    return 2;
    endcase
  endfunction

  // Expected outputs in cycle c (0-based) of an instruction
  function automatic logic [17:0] expect_at(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                                            input bit z, input bit n, input int c);
    logic [2:0] alu;
    bit         bad;
    bit         taken;
    if (c == 0) return mk(1, 0, 0, 1, 2'b10, 3'd0, 2'b00, 2'b10, 3'd0, 0, 0);
    if (c == 1) return mk(0, 0, 0, 0, 2'b00, 3'd0, 2'b01, 2'b01,
                          (o == 7'b1101111) ? 3'd2 : 3'd3, 0, !known_op(o));
    case (o)
      7'b0000011, 7'b0100011: begin
        if (c == 2) return mk(0, 0, 0, 0, 2'b00, 3'd0, 2'b10, 2'b01,
                              (o == 7'b0000011) ? 3'd0 : 3'd1, 0, 0);
        if (o == 7'b0100011) return mk(0, 1, 1, 0, 2'b00, 3'd0, 2'b00, 2'b00, 3'd0, 0, 0);
        if (c == 3) return mk(0, 1, 0, 0, 2'b00, 3'd0, 2'b00, 2'b00, 3'd0, 0, 0);
        return mk(0, 0, 0, 0, 2'b01, 3'd0, 2'b00, 2'b00, 3'd0, 1, 0);
      end
      7'b0110011, 7'b0010011: begin
        ref_alu(o == 7'b0110011, f3, f7, alu, bad);
        if (c == 2) return mk(0, 0, 0, 0, 2'b00, alu, 2'b10,
                              (o == 7'b0110011) ? 2'b00 : 2'b01, 3'd0, 0, bad);
        return mk(0, 0, 0, 0, 2'b00, 3'd0, 2'b00, 2'b00, 3'd0, 1, 0);
      end
      7'b1100011: begin
        bad   = !(f3 inside {3'd0, 3'd1, 3'd4, 3'd5});
        taken = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? n : (f3 == 3'd5) ? !n : 1'b0;
        return mk(taken, 0, 0, 0, 2'b00, 3'd1, 2'b10, 2'b00, 3'd0, 0, bad);
      end
      7'b1101111: begin
        if (c == 2) return mk(1, 0, 0, 0, 2'b00, 3'd0, 2'b01, 2'b10, 3'd0, 0, 0);
        return mk(0, 0, 0, 0, 2'b00, 3'd0, 2'b00, 2'b00, 3'd0, 1, 0);
      end
      7'b1100111: begin
        if (c == 2) return mk(0, 0, 0, 0, 2'b00, 3'd0, 2'b10, 2'b01, 3'd0, 0, 0);
        if (c == 3) return mk(1, 0, 0, 0, 2'b00, 3'd0, 2'b01, 2'b10, 3'd0, 0, 0);
        return mk(0, 0, 0, 0, 2'b00, 3'd0, 2'b00, 2'b00, 3'd0, 1, 0);
      end
      default: return mk(0, 0, 0, 0, 2'b11, 3'd0, 2'b00, 2'b00, 3'd4, 1, 0);
    endcase
  endfunction

  // Run one instruction from FETCH; optionally assert reset in cycle abort_at
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                           input bit z, input bit n, input int abort_at);
    int len;
    op = o; funct3 = f3; funct7_5 = f7; zero = z; neg = n;
    len = instr_len(o);
    for (int c = 0; c < len; c++) begin
      if (c == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        check($sformatf("abort_en op=%b c=%0d", o, c), 32'(dut_enables()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      @(negedge clk);
      check($sformatf("op=%b f3=%0d f7=%0d z=%0d n=%0d c=%0d", o, f3, f7, z, n, c),
            32'(dut_vec()), 32'(expect_at(o, f3, f7, z, n, c)));
      if (mem_write && reg_write)
        check("mw_rw_exclusive", 32'({mem_write, reg_write}), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  localparam logic [6:0] OPS[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                    7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                    7'b1111111};

  initial begin
    logic [6:0] ro;
    // Reset held for three cycles with a load in the IR
    rst = 1'b0;
    op  = 7'b0000011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_en%0d", i), 32'(dut_enables()), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed cases
    run_instr(7'b0000011, 3'd2, 0, 0, 0, -1);   // lw
    run_instr(7'b0100011, 3'd2, 0, 0, 0, -1);   // sw
    run_instr(7'b0110011, 3'd0, 1, 0, 0, -1);   // sub
    run_instr(7'b0010011, 3'd0, 1, 0, 0, -1);   // addi, funct7_5 ignored
    run_instr(7'b1100011, 3'd0, 0, 1, 0, -1);   // beq taken
    run_instr(7'b1100011, 3'd1, 0, 1, 0, -1);   // bne not taken
    run_instr(7'b1100011, 3'd4, 0, 0, 1, -1);   // blt taken
    run_instr(7'b1100011, 3'd2, 0, 1, 1, -1);   // illegal branch funct3
    run_instr(7'b0110011, 3'd1, 0, 0, 0, -1);   // unsupported R funct3
    run_instr(7'b1101111, 3'd0, 0, 0, 0, -1);   // jal
    run_instr(7'b1100111, 3'd0, 0, 0, 0, -1);   // jalr
    run_instr(7'b0110111, 3'd0, 0, 0, 0, -1);   // lui
    run_instr(7'b1111111, 3'd0, 0, 0, 0, -1);   // unknown opcode
    run_instr(7'b0100011, 3'd2, 0, 0, 0, 3);    // reset during MEMWRITE
    run_instr(7'b0000011, 3'd2, 0, 0, 0, 2);    // reset during MEMADR
    run_instr(7'b0110011, 3'd7, 0, 0, 0, -1);   // and after abort

    // Random instruction stream
    for (int i = 0; i < 200; i++) begin
      ro = OPS[$urandom_range(0, 8)];
      if (ro == 7'b1111111) ro = 7'($urandom);
      run_instr(ro, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_multicycle_controller
`default_nettype wire
